// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler
// Round-robin arbiter that shares one 16-bit SPI DAC serializer between
// NUM_CH requesters. Each requester has a one-deep holding register. The
// block builds the DAC command word and runs the serializer start/busy
// handshake, with an acknowledge timeout.
// Optional build macro: DAC_SCHED_LDAC_EN adds the ldac_n output and an LDAC
// state. In that state ldac_n pulses low for LDAC_LEN cycles after a burst
// drains, so all channels update together.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for enable, a pending channel and an idle serializer
// WAIT_ACK  | ser_start issued; waiting for ser_busy to rise (timeout)
// WAIT_DONE | serializer shifting; waiting for ser_busy to fall
// LDAC      | (LDAC_EN only) ldac_n held low for LDAC_LEN cycles
module dac_channel_scheduler #(
  parameter int NUM_CH      = 2,
  parameter int GAIN_1X     = 1,
  parameter int ACK_TIMEOUT = 15,
  parameter int LDAC_LEN    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*12-1:0] req_data,
  output logic [NUM_CH-1:0]    req_ready,
  output logic [15:0]          ser_frame,
  output logic                 ser_start,
  input  logic                 ser_busy,
  output logic                 dac_sel,
  output logic                 sched_busy,
  output logic [15:0]          frames_sent,
  output logic                 ack_err
`ifdef DAC_SCHED_LDAC_EN
  ,
  output logic                 ldac_n
`endif
);

  localparam int CW      = $clog2(NUM_CH);
  // One counter serves both the ack timeout and the LDAC pulse.
  localparam int CNT_MAX = (ACK_TIMEOUT > LDAC_LEN) ? ACK_TIMEOUT : LDAC_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
`ifdef DAC_SCHED_LDAC_EN
  localparam logic [1:0] S_LDAC      = 2'd3;
`endif

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_CH-1:0]       r_pending;
  logic [NUM_CH-1:0][11:0] r_data;
  logic [CW-1:0]           r_rr_ptr;
  logic [15:0]             r_frame;
  logic                    r_start;
  logic                    r_sel;
  logic [15:0]             r_frames_sent;
  logic                    r_ack_err;
`ifdef DAC_SCHED_LDAC_EN
  logic                    r_ldac_n;
`endif

  logic [NUM_CH-1:0]       w_accept;
  logic [NUM_CH-1:0]       w_clear;
  logic [CW-1:0]           w_grant;
  logic [CW-1:0]           w_scan;
  logic                    w_grant_vld;
  logic                    w_issue;
  logic [1:0]              w_grant_ext;

  assign w_accept    = req_valid & ~r_pending;
  assign w_issue     = (r_state == S_IDLE) && enable && w_grant_vld && !ser_busy;
  assign w_clear     = w_issue ? (NUM_CH'(1) << w_grant) : '0;
  assign w_grant_ext = 2'(w_grant);

  // Cyclic search from rr_ptr; scanning backwards lets the nearest pending channel win.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_scan      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_scan = r_rr_ptr + CW'(k);
      if (r_pending[w_scan]) begin
        w_grant     = w_scan;
        w_grant_vld = 1'b1;
      end
    end
  end

  // Holding registers: capture a code whenever the channel slot is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_data    <= '0;
    end else begin
      r_pending <= (r_pending | w_accept) & ~w_clear;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_accept[i]) r_data[i] <= req_data[12*i +: 12];
      end
    end
  end

  // Issue / handshake sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rr_ptr      <= '0;
      r_frame       <= '0;
      r_start       <= 1'b0;
      r_sel         <= 1'b0;
      r_frames_sent <= '0;
      r_ack_err     <= 1'b0;
`ifdef DAC_SCHED_LDAC_EN
      r_ldac_n      <= 1'b1;
`endif
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_frame  <= {w_grant_ext[0], 1'b0, 1'(GAIN_1X), 1'b1, r_data[w_grant]};
            r_sel    <= w_grant_ext[1];
            r_start  <= 1'b1;
            r_rr_ptr <= w_grant + CW'(1);
            r_cnt    <= CNT_W'(ACK_TIMEOUT);
            r_state  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (ser_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt <= CNT_W'(1)) begin
            // Frame is dropped, not re-queued.
            r_ack_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!ser_busy) begin
            r_frames_sent <= r_frames_sent + 16'd1;
`ifdef DAC_SCHED_LDAC_EN
            if (r_pending == '0) begin
              r_ldac_n <= 1'b0;
              r_cnt    <= CNT_W'(LDAC_LEN);
              r_state  <= S_LDAC;
            end else begin
              r_state <= S_IDLE;
            end
`else
            r_state <= S_IDLE;
`endif
          end
        end
`ifdef DAC_SCHED_LDAC_EN
        S_LDAC: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_ldac_n <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = ~r_pending;
  assign ser_frame   = r_frame;
  assign ser_start   = r_start;
  assign dac_sel     = r_sel;
  assign sched_busy  = (r_state != S_IDLE);
  assign frames_sent = r_frames_sent;
  assign ack_err     = r_ack_err;
`ifdef DAC_SCHED_LDAC_EN
  assign ldac_n      = r_ldac_n;
`endif

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Testbench for dac_channel_scheduler (NUM_CH=4) with a small serializer model.
module tb_dac_channel_scheduler;
  localparam int NCH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [47:0]   req_data = '0;
  logic [3:0]    req_ready;
  logic [15:0]   ser_frame;
  logic          ser_start;
  logic          ser_busy;
  logic          dac_sel;
  logic          sched_busy;
  logic [15:0]   frames_sent;
  logic          ack_err;
`ifdef DAC_SCHED_LDAC_EN
  logic          ldac_n;
`endif

  dac_channel_scheduler #(.NUM_CH(NCH), .GAIN_1X(1), .ACK_TIMEOUT(15), .LDAC_LEN(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ser_frame(ser_frame), .ser_start(ser_start), .ser_busy(ser_busy),
    .dac_sel(dac_sel), .sched_busy(sched_busy), .frames_sent(frames_sent),
    .ack_err(ack_err)
`ifdef DAC_SCHED_LDAC_EN
    , .ldac_n(ldac_n)
`endif
  );

  always #5 clk = ~clk;

  // Serializer model: busy rises the edge after ser_start and stays for busy_len cycles.
  int ser_mode = 0;
  int busy_len = 4;
  int bcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ser_busy <= 1'b0;
      bcnt     <= 0;
    end else if (ser_busy) begin
      if (bcnt <= 1) ser_busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end else if (ser_start && ser_mode == 0) begin
      ser_busy <= 1'b1;
      bcnt     <= busy_len;
    end
  end

  typedef struct {
    logic [3:0]       mask;
    logic [3:0][11:0] code;
    int               n;
    logic [3:0][15:0] fr;
    logic [3:0]       sel;
  } vec_t;

  vec_t        vecs[6];
  logic [16:0] q[$];
  logic [16:0] exp_e;
  int total = 0, bad = 0;
  int cyc = 0, n_starts = 0, last_start_cyc = 0;
  int fs_exp, k, ts, s0, ldac_low, fs_at_ldac;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Advance to the next falling edge and score any issued frame.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ser_start === 1'b1) begin
      n_starts++;
      last_start_cyc = cyc;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start: frame 0x%0h with nothing expected", ser_frame);
      end else begin
        exp_e = q.pop_front();
        chk("sb_frame", 32'(ser_frame), 32'(exp_e[15:0]));
        chk("sb_dac_sel", 32'(dac_sel), 32'(exp_e[16]));
      end
    end
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (!(q.size() == 0 && sched_busy === 1'b0 && ser_busy === 1'b0) && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no idle within %0d cycles, required idle", name, lim);
      q.delete();
    end
  endtask

  task automatic wait_busy(input logic lvl, input int lim);
    int n = 0;
    while (ser_busy !== lvl && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL wait_ser_busy: got %b after %0d cycles, required %b", ser_busy, lim, lvl);
    end
  endtask

  initial begin
    vecs[0] = '{mask:4'hF, code:{12'h004,12'h003,12'h002,12'h001}, n:4,
                fr:{16'hB004,16'h3003,16'hB002,16'h3001}, sel:4'b1100};
    vecs[1] = '{mask:4'h1, code:{12'h000,12'h000,12'h000,12'hABC}, n:1,
                fr:{16'h0,16'h0,16'h0,16'h3ABC}, sel:4'b0000};
    vecs[2] = '{mask:4'hA, code:{12'hFFF,12'h000,12'h123,12'h000}, n:2,
                fr:{16'h0,16'h0,16'hBFFF,16'hB123}, sel:4'b0010};
    vecs[3] = '{mask:4'h5, code:{12'h000,12'h800,12'h000,12'h000}, n:2,
                fr:{16'h0,16'h0,16'h3800,16'h3000}, sel:4'b0010};
    vecs[4] = '{mask:4'hF, code:{12'h444,12'h333,12'h222,12'h111}, n:4,
                fr:{16'h3333,16'hB222,16'h3111,16'hB444}, sel:4'b1001};
    vecs[5] = '{mask:4'h6, code:{12'h000,12'hA5A,12'h5A5,12'h000}, n:2,
                fr:{16'h0,16'h0,16'h3A5A,16'hB5A5}, sel:4'b0010};

    // Reset values
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'hF);
    chk("rst_ser_start", 32'(ser_start), 0);
    chk("rst_ser_frame", 32'(ser_frame), 0);
    chk("rst_dac_sel", 32'(dac_sel), 0);
    chk("rst_sched_busy", 32'(sched_busy), 0);
    chk("rst_frames_sent", 32'(frames_sent), 0);
    chk("rst_ack_err", 32'(ack_err), 0);
    reset_n = 1'b1;
    tick();

    // Table-driven bursts; round-robin pointer carries from one vector to the next.
    fs_exp = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = vecs[i].mask;
      req_data  = vecs[i].code;
      for (int j = 0; j < vecs[i].n; j++) q.push_back({vecs[i].sel[j], vecs[i].fr[j]});
      tick();
      req_valid = '0;
      wait_idle("vec", 300);
      fs_exp += vecs[i].n;
      chk("vec_frames_sent", 32'(frames_sent), 32'(fs_exp));
      chk("vec_ready_all", 32'(req_ready), 32'hF);
    end

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Single request: latency, ready low one cycle, count after busy falls.
    req_valid = 4'b0001;
    req_data  = 48'h000000000ABC;
    q.push_back({1'b0, 16'h3ABC});
    chk("single_ready_pre", 32'(req_ready[0]), 1);
    tick();
    chk("single_ready_low", 32'(req_ready[0]), 0);
    chk("single_no_start_e0", 32'(ser_start), 0);
    req_valid = '0;
    tick();
    chk("single_start_e1", 32'(ser_start), 1);
    chk("single_ready_back", 32'(req_ready[0]), 1);
    chk("single_sched_busy", 32'(sched_busy), 1);
    tick();
    chk("single_start_pulse", 32'(ser_start), 0);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 20);
    chk("single_fs_before", 32'(frames_sent), 0);
    tick();
    chk("single_fs_after", 32'(frames_sent), 1);
`ifdef DAC_SCHED_LDAC_EN
    chk("single_sched_done", 32'(sched_busy), 1);
`else
    chk("single_sched_done", 32'(sched_busy), 0);
`endif
    wait_idle("single", 50);

    // Buffering: new ch1 code accepted while ch1's frame is shifting.
    req_valid = 4'b0010;
    req_data  = 48'h0;
    req_data[23:12] = 12'h111;
    q.push_back({1'b0, 16'hB111});
    tick();
    req_valid = '0;
    wait_busy(1'b1, 20);
    req_data[23:12] = 12'h555;
    req_valid = 4'b0010;
    q.push_back({1'b0, 16'hB555});
    chk("buf_ready_while_busy", 32'(req_ready[1]), 1);
    tick();
    chk("buf_accepted", 32'(req_ready[1]), 0);
    chk("buf_ser_busy", 32'(ser_busy), 1);
    req_valid = '0;
    wait_idle("buf", 100);
    chk("buf_frames_sent", 32'(frames_sent), 3);

    // Enable low blocks issue; accepts continue; rr_ptr=2 so ch2 goes first.
    enable    = 1'b0;
    req_valid = 4'b0001;
    req_data  = 48'h0;
    req_data[11:0] = 12'h0F0;
    tick();
    req_valid = '0;
    s0 = n_starts;
    repeat (50) tick();
    req_valid = 4'b0100;
    req_data[35:24] = 12'h777;
    tick();
    req_valid = '0;
    repeat (49) tick();
    chk("en_no_start", 32'(n_starts), 32'(s0));
    chk("en_pending_kept", 32'(req_ready), 32'b1010);
    q.push_back({1'b1, 16'h3777});
    q.push_back({1'b0, 16'h30F0});
    enable = 1'b1;
    wait_idle("en", 100);
    chk("en_starts", 32'(n_starts), 32'(s0 + 2));
    chk("en_frames_sent", 32'(frames_sent), 5);

    // Ack timeout: serializer never goes busy.
    ser_mode  = 1;
    req_valid = 4'b1000;
    req_data  = 48'h0;
    req_data[47:36] = 12'h3C3;
    q.push_back({1'b1, 16'hB3C3});
    tick();
    req_valid = '0;
    k = 0;
    while (q.size() != 0 && k < 10) begin tick(); k++; end
    ts = last_start_cyc;
    k = 0;
    while (ack_err !== 1'b1 && k < 60) begin tick(); k++; end
    chk("to_delay", 32'(cyc - ts), 15);
    chk("to_ack_err", 32'(ack_err), 1);
    chk("to_idle", 32'(sched_busy), 0);
    chk("to_frames_kept", 32'(frames_sent), 5);
    chk("to_ready_all", 32'(req_ready), 32'hF);
    ser_mode  = 0;
    req_valid = 4'b0001;
    req_data  = 48'h000000000246;
    q.push_back({1'b0, 16'h3246});
    tick();
    req_valid = '0;
    wait_idle("to_after", 100);
    chk("to_after_frames", 32'(frames_sent), 6);
    chk("to_sticky", 32'(ack_err), 1);

    // Reset while in WAIT_DONE with another channel still pending.
    req_valid = 4'b0110;
    req_data  = 48'h0;
    req_data[23:12] = 12'h9AB;
    req_data[35:24] = 12'hCDE;
    q.push_back({1'b0, 16'hB9AB});
    tick();
    req_valid = '0;
    wait_busy(1'b1, 20);
    tick();
    chk("mid_in_frame", 32'(sched_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'hF);
    chk("mid_rst_frame", 32'(ser_frame), 0);
    chk("mid_rst_start", 32'(ser_start), 0);
    chk("mid_rst_sel", 32'(dac_sel), 0);
    chk("mid_rst_sched", 32'(sched_busy), 0);
    chk("mid_rst_fs", 32'(frames_sent), 0);
    chk("mid_rst_ack", 32'(ack_err), 0);
    q.delete();
    s0 = n_starts;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("mid_pending_dropped", 32'(n_starts), 32'(s0));

`ifdef DAC_SCHED_LDAC_EN
    // Burst of two: ldac_n pulses once, after the second frame, for 2 cycles.
    req_valid = 4'b0011;
    req_data  = 48'h000000222111;
    q.push_back({1'b0, 16'h3111});
    q.push_back({1'b0, 16'hB222});
    ldac_low   = 0;
    fs_at_ldac = -1;
    tick();
    req_valid = '0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (ldac_n === 1'b0) begin
        if (fs_at_ldac < 0) fs_at_ldac = int'(frames_sent);
        ldac_low++;
      end
    end
    chk("ldac_low_len", 32'(ldac_low), 2);
    chk("ldac_after_second", 32'(fs_at_ldac), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
